// File: rtl/debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : debounce_pkg                                              |
// | Brief    : State encoding and default constants for the debouncer.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_e;

  // 5 ms of hold time at a 100 MHz system clock.
  localparam int unsigned DEBOUNCE_CLKS_DEFAULT = 500_000;

endpackage
`default_nettype wire

// File: rtl/synchronizer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : synchronizer                                              |
// | Brief    : STAGES-deep flop chain bringing a pad level into clk.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], async_in};
    end
  end

  assign sync_out = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : debounce                                                  |
// | Brief    : Synchronizes a bouncing pad level and emits a clean level.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module debounce
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CLKS = DEBOUNCE_CLKS_DEFAULT,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int unsigned       c_CW   = $clog2(DEBOUNCE_CLKS);
  localparam logic [c_CW-1:0]   c_TERM = c_CW'(DEBOUNCE_CLKS - 1);

  logic            w_sync_in;
  state_e          r_state;
  state_e          w_state_nxt;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] w_count_nxt;
  logic            r_out;
  logic            w_out_nxt;

  synchronizer #(
    .STAGES   (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (in),
    .sync_out (w_sync_in)
  );

  // The counter defaults to 0, so every abort or acceptance discards partial credit.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = '0;
    w_out_nxt   = r_out;
    case (r_state)
      S_LOW: begin
        if (w_sync_in) w_state_nxt = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (!w_sync_in) begin
          w_state_nxt = S_LOW;
        end else if (r_count == c_TERM) begin
          w_state_nxt = S_HIGH;
          w_out_nxt   = 1'b1;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      S_HIGH: begin
        if (!w_sync_in) w_state_nxt = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (w_sync_in) begin
          w_state_nxt = S_HIGH;
        end else if (r_count == c_TERM) begin
          w_state_nxt = S_LOW;
          w_out_nxt   = 1'b0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_out_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOW;
      r_count <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign out = r_out;

endmodule
`default_nettype wire

// File: doc/debounce.md
# debounce

Input conditioner for a raw push-button or switch. It synchronizes the asynchronous pad signal into `clk`, then filters contact bounce with a four-state FSM and a stability counter. It outputs a clean, glitch-free level. The block sits directly upstream of the rising-edge one-shot: `out` of this block drives the one-shot's `in`, so each physical press yields exactly one pulse.

## Interface
- `DEBOUNCE_CLKS`, default 500_000, is the number of extra consecutive synchronized samples the input must hold before `out` follows it (5 ms at 100 MHz); legal range ≥ 2.
- `SYNC_STAGES`, default 2, is the synchronizer depth; legal range ≥ 2.
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  reset; asynchronous, active-low (asserted when 0).
- `in`  input  1  raw, asynchronous, bouncing button level.
- `out`  output  1  debounced level; registered.

## Operation
- **Synchronizer:** `SYNC_STAGES` flops in series; `sync_in` is the last stage. All flops are cleared to 0 by reset.
- **FSM states:**
  - `S_LOW`: stable 0, `out`=0.
  - `S_WAIT_HIGH`: candidate 1, `out`=0.
  - `S_HIGH`: stable 1, `out`=1.
  - `S_WAIT_LOW`: candidate 0, `out`=1.
- **Transitions**, all evaluated on `sync_in` at each rising `clk`:
  - `S_LOW`: if `sync_in`=1, go to `S_WAIT_HIGH` and set `count`=0; otherwise stay.
  - `S_WAIT_HIGH`:
    - `sync_in`=0 → back to `S_LOW`.
    - `sync_in`=1 and `count`=`DEBOUNCE_CLKS`-1 → go to `S_HIGH`.
    - otherwise `count`++.
  - `S_HIGH` / `S_WAIT_LOW`: mirror images of the above, with the polarity inverted.
- **Counter:** width `$clog2(DEBOUNCE_CLKS)`, unsigned. It never wraps, because the terminal compare occurs before any overflow. It is held at 0 in the stable states.
- `out` is a registered flop updated together with the state. It is not decoded combinationally from the state.
- **Reset values**, asynchronous on `rst`=0: state `S_LOW`, `count`=0, `out`=0, synchronizer flops 0.
- **Reset released with `in` already high:** behaves as a normal press. `out` rises after the full latency below.
- **Reset asserted mid-wait:** `out` drops to 0 immediately (asynchronously) and any partial count is discarded.

## Timing
- **Rise latency:** let edge e0 be the first edge at which sync flop 1 captures `in`=1, and assume `in` stays high. Then:
  - `sync_in` is 1 after edge e0+`SYNC_STAGES`-1.
  - The FSM enters `S_WAIT_HIGH` at edge e0+`SYNC_STAGES`.
  - `out`=1 after edge e0+`SYNC_STAGES`+`DEBOUNCE_CLKS`.
- **Fall latency:** identical, with the polarities swapped.
- **Acceptance rule:** a level is accepted only after `DEBOUNCE_CLKS`+1 consecutive identical `sync_in` samples, counting the one that triggered the wait state. Any shorter run is rejected and `out` does not change.
- **Bounce during a wait:** a single opposite sample aborts the wait. The next change restarts the count from 0, with no partial credit.
- `out` changes at most once per `DEBOUNCE_CLKS`+1 cycles.
- `out` is glitch-free, since it is driven directly by a flop.

## Structure
- **Package `debounce_pkg`:** `typedef enum logic [1:0]` for the four states. It also holds the default-constant `DEBOUNCE_CLKS_DEFAULT`=500_000, which the top level uses to derive the value from the clock frequency.
- **Sub-module `synchronizer`:**
  - Parameter `STAGES`; ports `clk`, `rst`, `async_in`, `sync_out`.
  - Uses the same asynchronous active-low reset.
  - Reusable for the other pad inputs.
- **Bench overrides:** benches set `DEBOUNCE_CLKS`=8 and `SYNC_STAGES`=2.

## Test plan
- **Reset:** hold `rst`=0 and toggle `in` → `out`=0 throughout. After release with `in`=0 → `out` stays 0 and the state is `S_LOW`.
- **Clean press:** `in` 0→1 and held; first capture at edge e0 → `out` rises after edge e0+10 (2+8), not earlier.
- **Bounce rejection:**
  - `in` high for 7 synchronized cycles, then low for 1, then high steadily → the count restarts.
  - `out` rises only 10 edges after the final 0→1 capture.
  - Overall, no `out` change occurs during any sub-9-sample run.
- **Clean release with bounce:** from `S_HIGH`, `in` toggles 1-0-1-0 with 3-cycle spacing, then stays 0 → `out` stays 1 until 10 edges after the last 1→0 capture, then falls exactly once.
- **Reset mid-operation:** assert `rst` in `S_WAIT_LOW` (`out`=1) → `out`=0 within the same cycle, without a clock edge. After release with `in`=1 → `out` rises after the full 10-edge latency.
- **Integration with the one-shot:** drive a 5-bounce press through `debounce` into the one-shot → exactly one 1-cycle pulse, occurring 1 cycle after `out` rises. No pulse occurs on release.
